// File: rtl/vec_alu_seq.sv
// ============================================================================
// Module   : vec_alu_seq
// Brief    : Serial vector ALU sequencer. It reads two vectors from the
//            register file, applies an elementwise op and writes the results back.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_alu_seq #(
    parameter int VLEN = 16,
    parameter int DW   = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [1:0]    i_op,
    input  logic [2:0]    i_src1,
    input  logic [2:0]    i_src2,
    input  logic [2:0]    i_dst,
    output logic [2:0]    o_addr,
    output logic [2:0]    o_addr2,
    output logic          o_rd_s,
    output logic          o_wr_s,
    output logic [DW-1:0] o_data_out_s,
    input  logic [DW-1:0] i_data_in_s,
    input  logic [DW-1:0] i_data_in2_s,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = $clog2(VLEN);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(VLEN - 1);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP_R = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_SETUP_W = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_op;
    logic [2:0]    r_src1, r_src2, r_dst;
    logic [DW-1:0] r_buf [VLEN];
    logic [DW-1:0] w_alu;

    logic [2:0]    r_addr, r_addr2, w_addr_nxt, w_addr2_nxt;
    logic          r_rd_s, r_wr_s, r_busy, r_done;
    logic          w_rd_nxt, w_wr_nxt, w_busy_nxt, w_done_nxt;
    logic [DW-1:0] r_data_out, w_data_nxt;
    logic [2:0]    w_src1_sel, w_src2_sel, w_dst_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_SETUP_R;
            S_SETUP_R: w_state_nxt = S_READ;
            S_READ:    if (r_cnt == c_CNT_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN:   w_state_nxt = S_SETUP_W;
            S_SETUP_W: w_state_nxt = S_WRITE;
            S_WRITE:   if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = '0;
        if ((r_state == S_READ  && w_state_nxt == S_READ) ||
            (r_state == S_WRITE && w_state_nxt == S_WRITE))
            w_cnt_nxt = r_cnt + c_ONE;
    end

    // Outputs are registered, so they are derived from the next state; on the
    // accepting edge the operands come straight from the inputs.
    assign w_src1_sel = (r_state == S_IDLE) ? i_src1 : r_src1;
    assign w_src2_sel = (r_state == S_IDLE) ? i_src2 : r_src2;
    assign w_dst_sel  = (r_state == S_IDLE) ? i_dst  : r_dst;

    always_comb begin
        w_rd_nxt    = (w_state_nxt == S_READ);
        w_wr_nxt    = (w_state_nxt == S_WRITE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_data_nxt  = w_wr_nxt ? r_buf[w_cnt_nxt] : '0;
        w_addr_nxt  = r_addr;
        w_addr2_nxt = r_addr2;
        case (w_state_nxt)
            S_SETUP_R, S_READ, S_DRAIN: begin
                w_addr_nxt  = w_src1_sel;
                w_addr2_nxt = w_src2_sel;
            end
            S_SETUP_W, S_WRITE, S_DONE: w_addr_nxt = w_dst_sel;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_addr2    <= '0;
            r_rd_s     <= 1'b0;
            r_wr_s     <= 1'b0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_op       <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_dst      <= '0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_addr2    <= w_addr2_nxt;
            r_rd_s     <= w_rd_nxt;
            r_wr_s     <= w_wr_nxt;
            r_data_out <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_op   <= i_op;
                r_src1 <= i_src1;
                r_src2 <= i_src2;
                r_dst  <= i_dst;
            end
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            2'b00: w_alu = i_data_in_s + i_data_in2_s;
            2'b01: w_alu = i_data_in_s - i_data_in2_s;
            2'b10: w_alu = i_data_in_s & i_data_in2_s;
            2'b11: w_alu = i_data_in_s | i_data_in2_s;
            default: w_alu = '0;
        endcase
    end

    // Read data lags the strobe by one cycle, hence the cnt-1 slot and DRAIN.
    always_ff @(posedge i_clk) begin
        if (r_state == S_READ && r_cnt != '0)
            r_buf[r_cnt - c_ONE] <= w_alu;
        else if (r_state == S_DRAIN)
            r_buf[c_CNT_LAST] <= w_alu;
    end

    assign o_addr       = r_addr;
    assign o_addr2      = r_addr2;
    assign o_rd_s       = r_rd_s;
    assign o_wr_s       = r_wr_s;
    assign o_data_out_s = r_data_out;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_vec_alu_seq.sv
// ============================================================================
// Module   : tb_vec_alu_seq
// Brief    : Self-checking bench for vec_alu_seq with a serial register-file model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vec_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [2:0]  src1 = '0, src2 = '0, dst = '0;
    logic [2:0]  addr, addr2;
    logic        rd_s, wr_s, busy, done;
    logic [15:0] dout;
    logic [15:0] din = '0, din2 = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] regs    [8][16];
    logic [15:0] ld_regs [8][16];
    logic        ld = 1'b0;
    int          rsel = 0;
    int          wsel = 0;

    always #5 clk = ~clk;

    vec_alu_seq #(.VLEN(16), .DW(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_src1(src1), .i_src2(src2), .i_dst(dst),
        .o_addr(addr), .o_addr2(addr2), .o_rd_s(rd_s), .o_wr_s(wr_s),
        .o_data_out_s(dout), .i_data_in_s(din), .i_data_in2_s(din2),
        .o_busy(busy), .o_done(done)
    );

    // Register file: registered serial read, serial write, select restarts after a gap
    always @(posedge clk) begin
        if (ld) begin
            regs <= ld_regs;
        end else begin
            if (rd_s) begin
                din  <= regs[addr][rsel];
                din2 <= regs[addr2][rsel];
                rsel <= rsel + 1;
            end else begin
                rsel <= 0;
            end
            if (wr_s) begin
                regs[addr][wsel] <= dout;
                wsel <= wsel + 1;
            end else begin
                wsel <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] alu_ref(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'd0:    return 16'((32'(a) + 32'(b)) % 65536);
            2'd1:    return 16'((32'(a) + 32'd65536 - 32'(b)) % 65536);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Called at a falling edge while idle; returns at a falling edge.
    task automatic commit_regs();
        ld = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"},  32'(addr),  32'd0);
        chk({tag, "_addr2"}, 32'(addr2), 32'd0);
        chk({tag, "_rd"},    32'(rd_s),  32'd0);
        chk({tag, "_wr"},    32'(wr_s),  32'd0);
        chk({tag, "_dout"},  32'(dout),  32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] f, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [2:0] d, input bit pulses);
        logic [15:0] exp_v [16];
        int rd_n = 0, wr_n = 0, rd_first = -1, wr_first = -1, rd_last = -1, wr_last = -1;
        int done_n = 0, done_c = -1, both_n = 0, busy_bad = 0, addr_bad = 0;
        for (int i = 0; i < 16; i++) exp_v[i] = alu_ref(f, regs[s1][i], regs[s2][i]);
        op = f; src1 = s1; src2 = s2; dst = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (rd_s) begin rd_n++; if (rd_first < 0) rd_first = c; rd_last = c; end
            if (wr_s) begin wr_n++; if (wr_first < 0) wr_first = c; wr_last = c; end
            if (rd_s && wr_s) both_n++;
            if (busy != (c <= 36)) busy_bad++;
            if (done) begin done_n++; done_c = c; end
            if (c <= 18 && (addr != s1 || addr2 != s2)) addr_bad++;
            if (c >= 19 && c <= 35 && addr != d) addr_bad++;
            if (pulses && (c == 9 || c == 30 || c == 36)) begin
                start = 1'b1;
                op = 2'($urandom); src1 = 3'($urandom); src2 = 3'($urandom); dst = 3'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, "_rd_count"}, 32'(rd_n), 32'd16);
        chk({tag, "_rd_span"},  32'(rd_last - rd_first + 1), 32'd16);
        chk({tag, "_rd_first"}, 32'(rd_first), 32'd2);
        chk({tag, "_wr_count"}, 32'(wr_n), 32'd16);
        chk({tag, "_wr_span"},  32'(wr_last - wr_first + 1), 32'd16);
        chk({tag, "_wr_first"}, 32'(wr_first), 32'd20);
        chk({tag, "_rdwr_overlap"}, 32'(both_n), 32'd0);
        chk({tag, "_done_count"}, 32'(done_n), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_c), 32'd36);
        chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_elem%0d", tag, i), 32'(regs[d][i]), 32'(exp_v[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 16; i++) ld_regs[r][i] = '0;
        @(negedge clk);
        commit_regs();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Add
        ld_regs = regs;
        for (int i = 0; i < 16; i++) begin
            ld_regs[1][i] = 16'(i);
            ld_regs[2][i] = 16'(i * 256);
        end
        commit_regs();
        run_op("add", 2'b00, 3'd1, 3'd2, 3'd3, 1'b0);
        chk("add_elem5_const", 32'(regs[3][5]), 32'h0505);

        // Subtract wraps
        ld_regs = regs;
        for (int i = 0; i < 16; i++) begin
            ld_regs[1][i] = 16'h0000;
            ld_regs[2][i] = 16'h0001;
        end
        commit_regs();
        run_op("sub_wrap", 2'b01, 3'd1, 3'd2, 3'd6, 1'b1);
        chk("sub_wrap_const", 32'(regs[6][0]), 32'hFFFF);

        // Aliased destination, and / or
        ld_regs = regs;
        for (int i = 0; i < 16; i++) begin
            ld_regs[4][i] = 16'hF0F0;
            ld_regs[5][i] = 16'h0FF0;
        end
        commit_regs();
        run_op("alias_and", 2'b10, 3'd4, 3'd5, 3'd4, 1'b0);
        chk("alias_and_const", 32'(regs[4][15]), 32'h00F0);
        ld_regs = regs;
        for (int i = 0; i < 16; i++) ld_regs[4][i] = 16'hF0F0;
        commit_regs();
        run_op("alias_or", 2'b11, 3'd4, 3'd5, 3'd4, 1'b1);
        chk("alias_or_const", 32'(regs[4][7]), 32'hFFF0);

        // Random operations, including aliasing and ignored Start pulses
        for (int n = 0; n < 6; n++) begin
            ld_regs = regs;
            for (int r = 0; r < 8; r++)
                for (int i = 0; i < 16; i++) ld_regs[r][i] = 16'($urandom);
            commit_regs();
            run_op($sformatf("rand%0d", n), 2'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), 1'($urandom));
        end

        // Reset during WRITE, with a Start asserted alongside it
        op = 2'b00; src1 = 3'd1; src2 = 3'd2; dst = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 25; c++) @(negedge clk);
        chk("pre_rst_wr", 32'(wr_s), 32'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        chk("mid_rst_stays_idle", 32'(busy), 32'd0);

        // Start coincident with reset while idle is dropped
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_dropped", 32'(busy), 32'd0);

        run_op("after_rst", 2'b00, 3'd1, 3'd2, 3'd7, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
